// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Mode-0 SPI master (sclk idles low, data launched on falling edges, sampled
// on rising edges). A frame is a DATA_W-bit write phase followed, optionally,
// by a DATA_W-bit read phase. The frame is framed by cs_n and followed by a
// CS_GAP-cycle deselect gap before done pulses.
//
// Build option:
//   SPI_MASTER_READ_EN  defined   -> frames include the READ phase
//                       undefined -> write-only frames, miso ignored,
//                                    rx_data held at 0
//
// Parameters:
//   DATA_W   bits per phase
//   CLK_DIV  clk cycles per sclk half-period (1..255)
//   CS_GAP   clk cycles cs_n stays high after a frame before done
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    frame request, accepted only when idle
//   tx_data  word to send MSB first, latched on accept
//   busy     high while a frame is in progress
//   done     one-cycle pulse at frame completion
//   rx_data  word read from the slave, updated with done
//   sclk     SPI clock
//   cs_n     chip select, active low
//   mosi     master-out data
//   miso     master-in data
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 1,
    parameter int CS_GAP  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        READ,
        HOLD,
        GAP
    } state_t;

    state_t            state, state_n;
    logic [7:0]        div_cnt, div_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic              sclk_q, sclk_n;
    logic              mosi_q, mosi_n;
    logic              cs_n_q, cs_n_n;
    logic              done_q, done_n;
    // Holds the bits still to be sent, already shifted one place so that the
    // MSB is always the next bit to present on a falling edge.
    logic [DATA_W-1:0] tx_shift, tx_n;

`ifdef SPI_MASTER_READ_EN
    logic [DATA_W-1:0] rx_shift, rx_n;
    logic [DATA_W-1:0] rx_data_q, rxd_n;
`else
    logic              unused_miso;
    assign unused_miso = miso;
`endif

    // State and datapath register. Reset wins over everything, including a
    // frame in flight, so an interrupted frame never reaches done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            tx_shift  <= '0;
`ifdef SPI_MASTER_READ_EN
            rx_shift  <= '0;
            rx_data_q <= '0;
`endif
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            bit_cnt   <= bit_n;
            gap_cnt   <= gap_n;
            sclk_q    <= sclk_n;
            mosi_q    <= mosi_n;
            cs_n_q    <= cs_n_n;
            done_q    <= done_n;
            tx_shift  <= tx_n;
`ifdef SPI_MASTER_READ_EN
            rx_shift  <= rx_n;
            rx_data_q <= rxd_n;
`endif
        end
    end

    // Next-state and next-output logic. Within WRITE and READ the level of
    // sclk tells which half-period is running: at the end of a high half sclk
    // falls, at the end of a low half the bit counter advances and sclk rises
    // again unless the phase is complete. The rising edge that opens READ is
    // also the first miso sample.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        gap_n   = gap_cnt;
        sclk_n  = sclk_q;
        mosi_n  = mosi_q;
        cs_n_n  = cs_n_q;
        done_n  = 1'b0;
        tx_n    = tx_shift;
`ifdef SPI_MASTER_READ_EN
        rx_n    = rx_shift;
        rxd_n   = rx_data_q;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    tx_n    = {tx_data[DATA_W-2:0], 1'b0};
                    mosi_n  = tx_data[DATA_W-1];
                    cs_n_n  = 1'b0;
                    sclk_n  = 1'b0;
                    div_n   = '0;
                    bit_n   = '0;
                    gap_n   = '0;
                    state_n = SETUP;
                end
            end

            SETUP: begin
                if (div_cnt == DIV_LAST) begin
                    div_n   = '0;
                    sclk_n  = 1'b1;
                    state_n = WRITE;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end

            WRITE: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (sclk_q) begin
                        sclk_n = 1'b0;
                        mosi_n = tx_shift[DATA_W-1];
                        tx_n   = {tx_shift[DATA_W-2:0], 1'b0};
                    end else if (bit_cnt == BIT_LAST) begin
                        bit_n = '0;
`ifdef SPI_MASTER_READ_EN
                        sclk_n  = 1'b1;
                        rx_n    = {rx_shift[DATA_W-2:0], miso};
                        state_n = READ;
`else
                        state_n = HOLD;
`endif
                    end else begin
                        bit_n  = bit_cnt + BIT_W'(1);
                        sclk_n = 1'b1;
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end

            READ: begin
`ifdef SPI_MASTER_READ_EN
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (sclk_q) begin
                        sclk_n = 1'b0;
                    end else if (bit_cnt == BIT_LAST) begin
                        bit_n   = '0;
                        state_n = HOLD;
                    end else begin
                        bit_n  = bit_cnt + BIT_W'(1);
                        sclk_n = 1'b1;
                        rx_n   = {rx_shift[DATA_W-2:0], miso};
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
`else
                state_n = HOLD;
`endif
            end

            HOLD: begin
                if (div_cnt == DIV_LAST) begin
                    div_n   = '0;
                    cs_n_n  = 1'b1;
                    state_n = GAP;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
`ifdef SPI_MASTER_READ_EN
                    rxd_n   = rx_shift;
`endif
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign sclk = sclk_q;
    assign cs_n = cs_n_q;
    assign mosi = mosi_q;
`ifdef SPI_MASTER_READ_EN
    assign rx_data = rx_data_q;
`else
    assign rx_data = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Directed bench for spi_master. One instance runs at default parameters with
// a mode-0 slave model on miso; a second instance runs with CLK_DIV=3 to check
// sclk timing and frame length. Expected values follow the build option
// SPI_MASTER_READ_EN so the bench suits both builds.
// -----------------------------------------------------------------------------
module tb_spi_master;

`ifdef SPI_MASTER_READ_EN
    localparam int          LEN0   = 74;
    localparam int          LEN3   = 206;
    localparam int          RISES  = 32;
    localparam logic [15:0] EXP_RX = 16'h3C5A;
`else
    localparam int          LEN0   = 42;
    localparam int          LEN3   = 110;
    localparam int          RISES  = 16;
    localparam logic [15:0] EXP_RX = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start3;
    logic [15:0] tx0, tx3;
    logic        busy0, done0, sclk0, cs0, mosi0, miso0;
    logic        busy3, done3, sclk3, cs3, mosi3, miso3;
    logic [15:0] rx0, rx3;

    int total = 0;
    int bad   = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    spi_master dut0 (
        .clk(clk), .rst(rst), .start(start0), .tx_data(tx0),
        .busy(busy0), .done(done0), .rx_data(rx0),
        .sclk(sclk0), .cs_n(cs0), .mosi(mosi0), .miso(miso0)
    );

    spi_master #(.DATA_W(16), .CLK_DIV(3), .CS_GAP(8)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .tx_data(tx3),
        .busy(busy3), .done(done3), .rx_data(rx3),
        .sclk(sclk3), .cs_n(cs3), .mosi(mosi3), .miso(miso3)
    );

    assign miso3 = 1'b0;

    // Mode-0 slave: counts falling sclk edges within the frame and, once the
    // write phase is over, shifts out resp MSB first, changing on each fall.
    int          fall_cnt = 0;
    logic [15:0] resp = 16'h3C5A;

    initial forever begin
        @(negedge sclk0 or posedge cs0);
        if (cs0 !== 1'b0) fall_cnt = 0;
        else              fall_cnt++;
    end

    assign miso0 = (fall_cnt >= 16 && fall_cnt < 32) ? resp[31 - fall_cnt] : 1'b0;

    // Frame monitor for dut0, sampled on the falling clk edge. Working values
    // restart when busy rises and are latched when busy falls. mosi is
    // captured on sclk rising edges, and any mosi change inside cs_n low that
    // is not accompanied by a falling sclk edge is counted as a violation.
    int          w_len, w_rise, l_len, l_rise, l_gap, cs_run, viol, done_cnt;
    logic [15:0] w_word, l_word;
    logic        p_busy = 1'b0, p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;

    initial begin
        w_len = 0; w_rise = 0; l_len = 0; l_rise = 0; l_gap = 0;
        cs_run = 0; viol = 0; done_cnt = 0; w_word = '0; l_word = '0;
        forever begin
            @(negedge clk);
            if (busy0 === 1'b1 && !p_busy) begin
                w_len = 0; w_rise = 0; w_word = '0;
            end
            if (busy0 === 1'b1) w_len++;
            if (sclk0 === 1'b1 && !p_sclk) begin
                if (w_rise < 16) w_word = {w_word[14:0], mosi0};
                w_rise++;
            end
            if (cs0 === 1'b0 && !p_cs && mosi0 !== p_mosi && !(sclk0 === 1'b0 && p_sclk))
                viol++;
            if (busy0 === 1'b0 && p_busy) begin
                l_len = w_len; l_rise = w_rise; l_word = w_word;
            end
            if (cs0 === 1'b1) begin
                cs_run++;
            end else if (p_cs) begin
                l_gap = cs_run;
                cs_run = 0;
            end
            if (done0 === 1'b1) done_cnt++;
            p_busy = (busy0 === 1'b1);
            p_sclk = (sclk0 === 1'b1);
            p_cs   = (cs0 !== 1'b0);
            p_mosi = mosi0;
        end
    end

    // Frame monitor for dut3: frame length, rising edge count, and the
    // shortest/longest sclk high run and low run (low runs counted only
    // between a falling edge and the next rising edge).
    int   m_len, m_rise, run, hi_min, hi_max, lo_min, lo_max;
    int   l3_len, l3_rise, l3_hi_min, l3_hi_max, l3_lo_min, l3_lo_max;
    logic q_busy = 1'b0, q_sclk = 1'b0, after_fall = 1'b0;

    initial begin
        m_len = 0; m_rise = 0; run = 0;
        hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
        l3_len = 0; l3_rise = 0; l3_hi_min = 0; l3_hi_max = 0;
        l3_lo_min = 0; l3_lo_max = 0;
        forever begin
            @(negedge clk);
            if (busy3 === 1'b1 && !q_busy) begin
                m_len = 0; m_rise = 0; run = 0; after_fall = 1'b0;
                hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
            end
            if (busy3 === 1'b1) m_len++;
            if ((sclk3 === 1'b1) != q_sclk) begin
                if (q_sclk) begin
                    if (run < hi_min) hi_min = run;
                    if (run > hi_max) hi_max = run;
                    after_fall = 1'b1;
                end else if (after_fall) begin
                    if (run < lo_min) lo_min = run;
                    if (run > lo_max) lo_max = run;
                end
                if (sclk3 === 1'b1) m_rise++;
                run = 1;
            end else begin
                run++;
            end
            if (busy3 === 1'b0 && q_busy) begin
                l3_len = m_len; l3_rise = m_rise;
                l3_hi_min = hi_min; l3_hi_max = hi_max;
                l3_lo_min = lo_min; l3_lo_max = lo_max;
            end
            q_busy = (busy3 === 1'b1);
            q_sclk = (sclk3 === 1'b1);
        end
    end

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One-cycle start pulse on dut0; returns one cycle after the accept edge.
    task automatic applyStimulus(input logic [15:0] tx);
        @(negedge clk);
        start0 = 1'b1;
        tx0    = tx;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    // Bounded wait for done0; an expired bound shows up as a failed check.
    task automatic waitDone0(input string tag);
        int n;
        n = 0;
        while (done0 !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, {31'd0, done0}, 32'd1);
    endtask

    // Waits for the end of a dut0 frame and checks its result and shape.
    task automatic checkFrame(input string tag, input logic [15:0] exp_word);
        waitDone0(tag);
        checkOutput({tag, "_rx"}, {16'd0, rx0}, {16'd0, EXP_RX});
        checkOutput({tag, "_busy_in_done"}, {31'd0, busy0}, 32'd0);
        exp_done++;
        @(negedge clk);
        checkOutput({tag, "_done_width"}, {31'd0, done0}, 32'd0);
        checkOutput({tag, "_busy_len"}, l_len, LEN0);
        checkOutput({tag, "_mosi_word"}, {16'd0, l_word}, {16'd0, exp_word});
        checkOutput({tag, "_rises"}, l_rise, RISES);
    endtask

    initial begin
        int n;
        rst = 1'b1; start0 = 1'b0; start3 = 1'b0; tx0 = '0; tx3 = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy0}, 32'd0);
        checkOutput("rst_cs_n", {31'd0, cs0}, 32'd1);
        checkOutput("rst_sclk", {31'd0, sclk0}, 32'd0);
        checkOutput("rst_mosi", {31'd0, mosi0}, 32'd0);
        checkOutput("rst_done", {31'd0, done0}, 32'd0);
        checkOutput("rst_rx", {16'd0, rx0}, 32'd0);
        rst = 1'b0;

        // Basic frame.
        applyStimulus(16'hA5C3);
        checkFrame("f1", 16'hA5C3);

        // A second request in the middle of a frame must be ignored.
        applyStimulus(16'hA5C3);
        repeat (19) @(negedge clk);
        start0 = 1'b1;
        tx0    = 16'h1234;
        @(negedge clk);
        start0 = 1'b0;
        checkFrame("ign", 16'hA5C3);
        repeat (3) @(negedge clk);
        checkOutput("ign_idle_after", {31'd0, busy0}, 32'd0);

        // Reset during write bit 7 abandons the frame without done.
        applyStimulus(16'hA5C3);
        repeat (15) @(negedge clk);
        checkOutput("midrst_busy_before", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_cs_n", {31'd0, cs0}, 32'd1);
        checkOutput("midrst_sclk", {31'd0, sclk0}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy0}, 32'd0);
        checkOutput("midrst_rx", {16'd0, rx0}, 32'd0);
        repeat (100) @(negedge clk);
        checkOutput("midrst_no_done", done_cnt, exp_done);
        applyStimulus(16'hA5C3);
        checkFrame("after_rst", 16'hA5C3);

        // start held high: each done cycle accepts the next frame.
        @(negedge clk);
        start0 = 1'b1;
        tx0    = 16'h0000;
        @(negedge clk);
        tx0 = 16'h0001;
        checkFrame("b2b0", 16'h0000);
        checkOutput("b2b1_accepted", {31'd0, busy0}, 32'd1);
        tx0 = 16'h0002;
        checkFrame("b2b1", 16'h0001);
        checkOutput("b2b2_accepted", {31'd0, busy0}, 32'd1);
        start0 = 1'b0;
        checkFrame("b2b2", 16'h0002);
        checkOutput("b2b_cs_gap", l_gap, 9);
        repeat (3) @(negedge clk);
        checkOutput("b2b_stopped", {31'd0, busy0}, 32'd0);
        checkOutput("done_count", done_cnt, exp_done);
        checkOutput("mosi_only_on_fall", viol, 0);

        // Divided clock.
        @(negedge clk);
        start3 = 1'b1;
        tx3    = 16'h0001;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("d3_done_seen", {31'd0, done3}, 32'd1);
        checkOutput("d3_rx", {16'd0, rx3}, 32'd0);
        @(negedge clk);
        checkOutput("d3_busy_len", l3_len, LEN3);
        checkOutput("d3_rises", l3_rise, RISES);
        checkOutput("d3_hi_min", l3_hi_min, 3);
        checkOutput("d3_hi_max", l3_hi_max, 3);
        checkOutput("d3_lo_min", l3_lo_min, 3);
        checkOutput("d3_lo_max", l3_lo_max, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
